// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants, FSM state type and address check for mem_arbiter
package mem_arb_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Only addresses up to MAX_ADDR are allowed to reach the memory.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return addr <= MAX_ADDR;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker owning the last-grant pointer
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  // 0 = port 0 granted last, 1 = port 1; reset to 1 so port 0 wins the first conflict.
  logic last_grant_q, last_grant_d;

  // Lone requester always wins; on conflict the port that did not win last time is picked.
  always_comb begin
    grant_o = valid_i;
    if (&valid_i) begin
      grant_o = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer advances only when the grant is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (update_i) begin
      last_grant_d = grant_o[1];
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of an 8x8 memory
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_valid,
  input  logic              p1_valid,
  output logic              p0_ready,
  output logic              p1_ready,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_resp_valid,
  output logic              p1_resp_valid,
  output logic              p0_resp_err,
  output logic              p1_resp_err,
  output logic [DATA_W-1:0] p0_resp_rdata,
  output logic [DATA_W-1:0] p1_resp_rdata,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] addr_w,
  output logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_q, gnt_d;
  logic              err_q, err_d;

  logic [1:0]        grant;
  logic              accept_en;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A new request may be taken in IDLE and also in RESP, so the edge that ends
  // a response can already accept the next request (back-to-back throughput).
  assign accept_en = (state_q == IDLE) || (state_q == RESP);
  assign accept    = accept_en && (p0_valid || p1_valid);

  rr_arb2 u_rr_arb2 (
    .clock    (clock),
    .reset_n  (reset_n),
    .valid_i  ({p1_valid, p0_valid}),
    .update_i (accept),
    .grant_o  (grant)
  );

  assign sel_we    = grant[1] ? p1_we    : p0_we;
  assign sel_addr  = grant[1] ? p1_addr  : p0_addr;
  assign sel_wdata = grant[1] ? p1_wdata : p0_wdata;

  // Next-state and request/response register updates.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          gnt_d   = grant[1];
          rdata_d = '0;
          if (addr_ok(sel_addr)) begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ISSUE:   state_d = we_q ? RESP : CAPTURE;
      CAPTURE: begin
        rdata_d = dataout;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request/response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  assign p0_ready = accept_en & grant[0];
  assign p1_ready = accept_en & grant[1];

  assign p0_resp_valid = (state_q == RESP) & ~gnt_q;
  assign p1_resp_valid = (state_q == RESP) &  gnt_q;
  assign p0_resp_err   = p0_resp_valid & err_q;
  assign p1_resp_err   = p1_resp_valid & err_q;
  assign p0_resp_rdata = p0_resp_valid ? rdata_q : '0;
  assign p1_resp_rdata = p1_resp_valid ? rdata_q : '0;

  // Strobes decode straight from the state so a reset drops them at once.
  assign write  = (state_q == ISSUE) &  we_q;
  assign read   = (state_q == ISSUE) & ~we_q;
  assign addr_w = addr_q;
  assign addr_r = addr_q;
  assign datain = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  valid_v = 2'b00;
  logic [1:0]  we_v = 2'b00;
  logic [2:0]  addr_v [2];
  logic [7:0]  wdata_v [2];
  wire  [1:0]  ready;
  wire  [1:0]  resp_valid;
  wire  [1:0]  resp_err;
  wire  [7:0]  rdata0, rdata1;
  wire         write, read;
  wire  [2:0]  addr_w, addr_r;
  wire  [7:0]  datain;
  logic [7:0]  dataout;

  logic [7:0]  mem [8] = '{default: 8'h00};
  logic [7:0]  ref_mem [8] = '{default: 8'h00};

  int n_vec = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .p0_valid      (valid_v[0]),
    .p1_valid      (valid_v[1]),
    .p0_ready      (ready[0]),
    .p1_ready      (ready[1]),
    .p0_we         (we_v[0]),
    .p1_we         (we_v[1]),
    .p0_addr       (addr_v[0]),
    .p1_addr       (addr_v[1]),
    .p0_wdata      (wdata_v[0]),
    .p1_wdata      (wdata_v[1]),
    .p0_resp_valid (resp_valid[0]),
    .p1_resp_valid (resp_valid[1]),
    .p0_resp_err   (resp_err[0]),
    .p1_resp_err   (resp_err[1]),
    .p0_resp_rdata (rdata0),
    .p1_resp_rdata (rdata1),
    .write         (write),
    .read          (read),
    .addr_w        (addr_w),
    .addr_r        (addr_r),
    .datain        (datain),
    .dataout       (dataout)
  );

  // Memory: write and read data registered on the strobe edge.
  always @(posedge clock) begin
    if (write) mem[addr_w] <= datain;
    if (read)  dataout <= mem[addr_r];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Invariants over every live cycle.
  always @(negedge clock) begin
    if (mon_on && reset_n) begin
      chk("ready_onehot", {31'd0, ready == 2'b11}, 32'd0);
      chk("strobe_excl", {31'd0, write & read}, 32'd0);
    end
  end

  function automatic logic [7:0] rd_of(input int p);
    return (p == 1) ? rdata1 : rdata0;
  endfunction

  // Transaction-level rules: invalid address -> err after 1 edge, write -> 2, read -> 3.
  task automatic model(input bit w, input logic [2:0] a, output logic e_err,
                       output logic [7:0] e_rd, output int e_lat);
    if (a > 3'd6) begin
      e_err = 1'b1; e_rd = 8'h00; e_lat = 1;
    end else if (w) begin
      e_err = 1'b0; e_rd = 8'h00; e_lat = 2;
    end else begin
      e_err = 1'b0; e_rd = ref_mem[a]; e_lat = 3;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {30'd0, ready}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, resp_valid}, 32'd0);
    chk({tag, "_rerr"}, {30'd0, resp_err}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, rdata1, rdata0}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, write, read}, 32'd0);
    chk({tag, "_addr"}, {26'd0, addr_w, addr_r}, 32'd0);
    chk({tag, "_datain"}, {24'd0, datain}, 32'd0);
  endtask

  task automatic drive(input int p, input bit w, input logic [2:0] a, input logic [7:0] d);
    valid_v[p] = 1'b1;
    we_v[p]    = w;
    addr_v[p]  = a;
    wdata_v[p] = d;
  endtask

  // Called at the negedge where ready[p] is high; the next posedge is the accept edge.
  task automatic await_resp(input int p, input bit w, input logic [2:0] a, input logic [7:0] d,
                            input logic e_err, input logic [7:0] e_rd, input int e_lat,
                            input string tag);
    int lat;
    @(negedge clock);
    valid_v[p] = 1'b0;
    if (e_err) begin
      chk({tag, "_nostrobe"}, {30'd0, write, read}, 32'd0);
    end else begin
      chk({tag, "_strobe"}, {30'd0, write, read}, {30'd0, w, ~w});
      chk({tag, "_maddr"}, {29'd0, w ? addr_w : addr_r}, {29'd0, a});
      if (w) chk({tag, "_datain"}, {24'd0, datain}, {24'd0, d});
    end
    lat = 1;
    while (!resp_valid[p] && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_other_rv"}, {31'd0, resp_valid[1-p]}, 32'd0);
    chk({tag, "_err"}, {31'd0, resp_err[p]}, {31'd0, e_err});
    chk({tag, "_rdata"}, {24'd0, rd_of(p)}, {24'd0, e_rd});
    if (!e_err && w) ref_mem[a] = d;
    @(negedge clock);
    chk({tag, "_pulse"}, {31'd0, resp_valid[p]}, 32'd0);
  endtask

  task automatic txn(input int p, input bit w, input logic [2:0] a, input logic [7:0] d,
                     input logic e_err, input logic [7:0] e_rd, input int e_lat,
                     input string tag);
    int c;
    @(negedge clock);
    drive(p, w, a, d);
    #1;
    c = 0;
    while (!ready[p] && c < 20) begin
      @(negedge clock);
      #1;
      c++;
    end
    chk({tag, "_ready"}, {31'd0, ready[p]}, 32'd1);
    if (!ready[p]) begin
      valid_v[p] = 1'b0;
      return;
    end
    await_resp(p, w, a, d, e_err, e_rd, e_lat, tag);
  endtask

  typedef struct {
    int         port;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int         grants [$];
    logic       e_err;
    logic [7:0] e_rd;
    int         e_lat;
    int         p;
    bit         w;
    logic [2:0] a;
    logic [7:0] d;

    // Expected values follow from the memory contents left by the conflict test
    // (mem[0]=AA, mem[4]=10) plus earlier rows of this table.
    tbl[0] = '{0, 1'b1, 3'd5, 8'h05, 1'b0, 8'h00, 2};
    tbl[1] = '{0, 1'b0, 3'd5, 8'h00, 1'b0, 8'h05, 3};
    tbl[2] = '{1, 1'b0, 3'd7, 8'h00, 1'b1, 8'h00, 1};
    tbl[3] = '{1, 1'b1, 3'd7, 8'hFF, 1'b1, 8'h00, 1};
    tbl[4] = '{1, 1'b1, 3'd2, 8'h3C, 1'b0, 8'h00, 2};
    tbl[5] = '{0, 1'b0, 3'd2, 8'h00, 1'b0, 8'h3C, 3};
    tbl[6] = '{1, 1'b0, 3'd0, 8'h00, 1'b0, 8'hAA, 3};
    tbl[7] = '{0, 1'b0, 3'd3, 8'h00, 1'b0, 8'h00, 3};

    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;

    repeat (3) @(negedge clock);
    check_reset_outputs("rst_in");
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs("rst_out");
    mon_on = 1'b1;

    // Both ports requesting continuously: grants must alternate starting with p0.
    drive(0, 1'b1, 3'd0, 8'hAA);
    drive(1, 1'b1, 3'd4, 8'h10);
    for (int i = 0; i < 30 && grants.size() < 4; i++) begin
      #1;
      if (ready[0]) grants.push_back(0);
      else if (ready[1]) grants.push_back(1);
      @(negedge clock);
    end
    valid_v = 2'b00;
    repeat (4) @(negedge clock);
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) chk($sformatf("rr_order%0d", i), grants[i], i % 2);
    ref_mem[0] = 8'hAA;
    ref_mem[4] = 8'h10;
    txn(0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hAA, 3, "rr_rd0");
    txn(1, 1'b0, 3'd4, 8'h00, 1'b0, 8'h10, 3, "rr_rd4");

    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
          tbl[i].err, tbl[i].rdata, tbl[i].lat, $sformatf("tbl%0d", i));
    end

    // p1 read accepted on the edge that ends p0's write response.
    @(negedge clock);
    drive(0, 1'b1, 3'd6, 8'h09);
    #1;
    chk("ovl_p0_ready", {31'd0, ready[0]}, 32'd1);
    @(negedge clock);
    valid_v[0] = 1'b0;
    chk("ovl_write", {31'd0, write}, 32'd1);
    chk("ovl_waddr", {29'd0, addr_w}, 32'd6);
    chk("ovl_datain", {24'd0, datain}, 32'h09);
    @(negedge clock);
    chk("ovl_p0_resp", {31'd0, resp_valid[0]}, 32'd1);
    ref_mem[6] = 8'h09;
    drive(1, 1'b0, 3'd6, 8'h00);
    #1;
    chk("ovl_p1_ready", {30'd0, ready}, 32'd2);
    await_resp(1, 1'b0, 3'd6, 8'h00, 1'b0, 8'h09, 3, "ovl_p1");

    // Reset during CAPTURE of a p0 read drops the request without a response.
    @(negedge clock);
    drive(0, 1'b0, 3'd5, 8'h00);
    #1;
    chk("rstc_ready", {31'd0, ready[0]}, 32'd1);
    @(negedge clock);
    valid_v[0] = 1'b0;
    chk("rstc_read", {31'd0, read}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rstc");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rstc_norv%0d", i), {30'd0, resp_valid}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    chk("rstc_post_rv", {30'd0, resp_valid}, 32'd0);
    txn(1, 1'b0, 3'd5, 8'h00, 1'b0, ref_mem[5], 3, "rstc_p1rd");

    // Randomized single-requester traffic against the transaction model.
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      model(w, a, e_err, e_rd, e_lat);
      txn(p, w, a, d, e_err, e_rd, e_lat, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
